// File: rtl/pe_pkg.sv
// Shared definitions for the PE multiply-accumulate pipeline:
// default widths, saturation limit helpers and the sideband flag bundle.
package pe_pkg;

  localparam int DATA_BITWIDTH_DEF = 8;
  localparam int PSUM_BITWIDTH_DEF = 24;
  localparam int PSUM_W_MAX        = 64;

  // Travels with psum_in through the multiplier delay line
  typedef struct packed {
    logic first;
    logic last;
  } pe_flags_t;

  function automatic int prod_width(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic logic [PSUM_W_MAX-1:0] sat_max(input int psum_w, input logic is_signed);
    logic [PSUM_W_MAX-1:0] v;
    int                    top;
    v   = '0;
    top = is_signed ? psum_w - 32'sd1 : psum_w;
    for (int i = 0; i < PSUM_W_MAX; i++) begin
      if (i < top) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  // Unsigned sums cannot underflow, so the unsigned minimum is never selected
  function automatic logic [PSUM_W_MAX-1:0] sat_min(input int psum_w, input logic is_signed);
    logic [PSUM_W_MAX-1:0] v;
    v = '0;
    if (is_signed && (psum_w > 32'sd0) && (psum_w <= PSUM_W_MAX)) begin
      v[psum_w-1] = 1'b1;
    end else begin
      v = '0;
    end
    return v;
  endfunction

endpackage

// File: rtl/pe_mac_pipe_mult.sv
// Registered multiplier: stage 1 holds the operands, later stages hold the product.
// Valid and sideband are delayed alongside; the whole chain freezes when i_en is low.
module pe_mult_pipe
  import pe_pkg::*;
#(
  parameter int DW     = DATA_BITWIDTH_DEF,
  parameter int SB_W   = PSUM_BITWIDTH_DEF + 2,
  parameter int STAGES = 2,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [DW-1:0]     i_a,
  input  logic [DW-1:0]     i_b,
  input  logic [SB_W-1:0]   i_sb,
  output logic              o_valid,
  output logic [2*DW-1:0]   o_prod,
  output logic [SB_W-1:0]   o_sb
);

  localparam int PW = prod_width(DW);

  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [STAGES-1:0] r_v;
  logic [SB_W-1:0] r_sb [STAGES];
  logic [PW-1:0]   w_a_ext;
  logic [PW-1:0]   w_b_ext;
  logic [PW-1:0]   w_prod;

  // Low PW bits of the extended product are exact for both signednesses
  assign w_a_ext = (SIGNED != 0) ? {{DW{r_a[DW-1]}}, r_a} : {{DW{1'b0}}, r_a};
  assign w_b_ext = (SIGNED != 0) ? {{DW{r_b[DW-1]}}, r_b} : {{DW{1'b0}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Operand capture plus the valid/sideband delay line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_sb[k] <= '0;
      end
    end else if (i_en) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_v[0]  <= i_valid;
      r_sb[0] <= i_sb;
      for (int k = 1; k < STAGES; k++) begin
        r_v[k]  <= r_v[k-1];
        r_sb[k] <= r_sb[k-1];
      end
    end
  end

  generate
    if (STAGES == 1) begin : g_one
      assign o_prod = w_prod;
    end else begin : g_multi
      logic [PW-1:0] r_p [STAGES-1];
      // Product delay stages
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < STAGES - 1; k++) begin
            r_p[k] <= '0;
          end
        end else if (i_en) begin
          r_p[0] <= w_prod;
          for (int k = 1; k < STAGES - 1; k++) begin
            r_p[k] <= r_p[k-1];
          end
        end
      end
      assign o_prod = r_p[STAGES-2];
    end
  endgenerate

  assign o_valid = r_v[STAGES-1];
  assign o_sb    = r_sb[STAGES-1];

endmodule

// File: rtl/pe_mac_pipe.sv
// Pipelined PE multiply-accumulate: psum += iact*wght over first/last framed beats,
// signed or unsigned, saturating or wrapping, with valid/ready backpressure.
module pe_mac_pipe
  import pe_pkg::*;
#(
  parameter int DATA_BITWIDTH = DATA_BITWIDTH_DEF,
  parameter int PSUM_BITWIDTH = PSUM_BITWIDTH_DEF,
  parameter int MULT_STAGES   = 2,
  parameter int SIGNED        = 1,
  parameter int SATURATE      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_BITWIDTH-1:0] iact,
  input  logic [DATA_BITWIDTH-1:0] wght,
  input  logic [PSUM_BITWIDTH-1:0] psum_in,
  input  logic                     in_first,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PSUM_BITWIDTH-1:0] psum_out,
  output logic                     ovf
);

  localparam int PW   = prod_width(DATA_BITWIDTH);
  localparam int GW   = PSUM_BITWIDTH + 1;
  localparam int SB_W = PSUM_BITWIDTH + $bits(pe_flags_t);
  localparam logic [PSUM_W_MAX-1:0]    SAT_HI_FULL = sat_max(PSUM_BITWIDTH, SIGNED != 0);
  localparam logic [PSUM_W_MAX-1:0]    SAT_LO_FULL = sat_min(PSUM_BITWIDTH, SIGNED != 0);
  localparam logic [PSUM_BITWIDTH-1:0] SAT_HI      = SAT_HI_FULL[PSUM_BITWIDTH-1:0];
  localparam logic [PSUM_BITWIDTH-1:0] SAT_LO      = SAT_LO_FULL[PSUM_BITWIDTH-1:0];

  logic                     w_stall;
  logic                     w_mv;
  logic [PW-1:0]            w_prod;
  pe_flags_t                w_flags_in;
  pe_flags_t                w_flags;
  logic [SB_W-1:0]          w_sb_in;
  logic [SB_W-1:0]          w_sb_out;
  logic [PSUM_BITWIDTH-1:0] w_sb_psum;
  logic [PSUM_BITWIDTH-1:0] w_base;
  logic [PSUM_BITWIDTH-1:0] w_res;
  logic [GW-1:0]            w_base_g;
  logic [GW-1:0]            w_prod_g;
  logic [GW-1:0]            w_sum_g;
  logic                     w_ovf_beat;
  logic                     w_ovf_new;
  logic [PSUM_BITWIDTH-1:0] r_acc;
  logic                     r_ovf_acc;
  logic [PSUM_BITWIDTH-1:0] r_psum_out;
  logic                     r_ovf_out;
  logic                     r_out_valid;

  assign w_stall    = r_out_valid & ~out_ready;
  assign in_ready   = ~w_stall;
  assign w_flags_in = '{first: in_first, last: in_last};
  assign w_sb_in    = {psum_in, w_flags_in};
  assign {w_sb_psum, w_flags} = w_sb_out;

  pe_mult_pipe #(
    .DW     (DATA_BITWIDTH),
    .SB_W   (SB_W),
    .STAGES (MULT_STAGES),
    .SIGNED (SIGNED)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .i_en    (~w_stall),
    .i_valid (in_valid),
    .i_a     (iact),
    .i_b     (wght),
    .i_sb    (w_sb_in),
    .o_valid (w_mv),
    .o_prod  (w_prod),
    .o_sb    (w_sb_out)
  );

  // Guard-bit add; the guard bit is the true sign (signed) or carry (unsigned)
  always_comb begin
    w_base     = r_acc;
    w_base_g   = '0;
    w_prod_g   = '0;
    w_sum_g    = '0;
    w_ovf_beat = 1'b0;
    w_res      = '0;
    w_ovf_new  = 1'b0;
    if (w_flags.first) begin
      w_base = w_sb_psum;
    end else begin
      w_base = r_acc;
    end
    if (SIGNED != 0) begin
      w_base_g = {w_base[PSUM_BITWIDTH-1], w_base};
      w_prod_g = {{(GW-PW){w_prod[PW-1]}}, w_prod};
    end else begin
      w_base_g = {1'b0, w_base};
      w_prod_g = {{(GW-PW){1'b0}}, w_prod};
    end
    w_sum_g = w_base_g + w_prod_g;
    if (SIGNED != 0) begin
      w_ovf_beat = w_sum_g[GW-1] ^ w_sum_g[GW-2];
    end else begin
      w_ovf_beat = w_sum_g[GW-1];
    end
    if (w_ovf_beat && (SATURATE != 0)) begin
      if ((SIGNED != 0) && w_sum_g[GW-1]) begin
        w_res = SAT_LO;
      end else begin
        w_res = SAT_HI;
      end
    end else begin
      w_res = w_sum_g[PSUM_BITWIDTH-1:0];
    end
    if (w_flags.first) begin
      w_ovf_new = w_ovf_beat;
    end else begin
      w_ovf_new = r_ovf_acc | w_ovf_beat;
    end
  end

  // Accumulator update and result emit; a completing last beat wins over the drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_ovf_acc   <= 1'b0;
      r_psum_out  <= '0;
      r_ovf_out   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (!w_stall) begin
      if (w_mv) begin
        r_acc     <= w_res;
        r_ovf_acc <= w_ovf_new;
      end
      if (w_mv && w_flags.last) begin
        r_psum_out  <= w_res;
        r_ovf_out   <= w_ovf_new;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign psum_out  = r_psum_out;
  assign ovf       = r_ovf_out;

endmodule
